// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder controller.
// Optional feature macro: BCD_SUB_EN (enables the nines-complement helper).
package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int BCD_CORR      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef BCD_SUB_EN
  // Nines complement of one BCD digit; invalid digits simply wrap.
  function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] d);
    return BCD_DIGIT_W'(BCD_MAX_DIGIT) - d;
  endfunction
`endif

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with >9 / +6 decimal correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] sum,
  output logic                   cout
);

  logic [BCD_DIGIT_W:0] s5;
  logic [BCD_DIGIT_W:0] s5_corr;

  // Binary digit sum, then decimal correction when it exceeds nine.
  always_comb begin
    s5      = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
    s5_corr = s5 + (BCD_DIGIT_W + 1)'(BCD_CORR);
    sum     = s5[BCD_DIGIT_W-1:0];
    cout    = 1'b0;
    if (s5 > (BCD_DIGIT_W + 1)'(BCD_MAX_DIGIT)) begin
      sum  = s5_corr[BCD_DIGIT_W-1:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder controller: one shared digit adder walks the
// operands least-significant digit first, one digit per clock.
// Optional feature macro: BCD_SUB_EN (adds the sub port, nines-complement of B).
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] b,
  input  logic                            cin,
`ifdef BCD_SUB_EN
  input  logic                            sub,
`endif
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] sum,
  output logic                            cout,
  output logic                            err
);

  localparam int W   = BCD_DIGIT_W * N_DIGITS;
  localparam int K_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t                 state;
  state_t                 state_n;
  logic [W-1:0]           a_reg;
  logic [W-1:0]           b_reg;
`ifdef BCD_SUB_EN
  logic                   sub_reg;
`endif
  logic                   carry;
  logic [K_W-1:0]         k;
  logic                   last;
  logic [BCD_DIGIT_W-1:0] a_dig;
  logic [BCD_DIGIT_W-1:0] b_dig;
  logic [BCD_DIGIT_W-1:0] b_eff;
  logic [BCD_DIGIT_W-1:0] d_sum;
  logic                   d_cout;
  logic                   dig_err;

  // Digit mux: select operand digit k and apply the optional complement.
  always_comb begin
    a_dig   = a_reg[BCD_DIGIT_W*k +: BCD_DIGIT_W];
    b_dig   = b_reg[BCD_DIGIT_W*k +: BCD_DIGIT_W];
    b_eff   = b_dig;
`ifdef BCD_SUB_EN
    if (sub_reg) b_eff = nines_comp(b_dig);
`endif
    dig_err = (a_dig > BCD_DIGIT_W'(BCD_MAX_DIGIT)) |
              (b_dig > BCD_DIGIT_W'(BCD_MAX_DIGIT));
    last    = (k == K_W'(N_DIGITS - 1));
  end

  bcd_digit_add u_digit_add (
    .a    (a_dig),
    .b    (b_eff),
    .cin  (carry),
    .sum  (d_sum),
    .cout (d_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and status outputs, decoded from registered state only.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture and per-digit result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
`ifdef BCD_SUB_EN
      sub_reg <= 1'b0;
`endif
      carry   <= 1'b0;
      k       <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
`ifdef BCD_SUB_EN
            sub_reg <= sub;
`endif
            carry   <= cin;
            k       <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
          end
        end
        RUN: begin
          sum[BCD_DIGIT_W*k +: BCD_DIGIT_W] <= d_sum;
          carry <= d_cout;
          err   <= err | dig_err;
          if (last) cout <= d_cout;
          else      k    <= k + K_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (N_DIGITS=4).
// Honours BCD_SUB_EN to exercise subtraction when the feature is built in.
module tb_bcd_serial_adder_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   a = '0;
  logic [15:0]   b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          busy, done, cout, err;
  logic [15:0]   sum;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl #(.N_DIGITS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef BCD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference for valid operands.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic sb_sub);
    exp_t e;
    int t;
    t = bcd2int(av) + (sb_sub ? (9999 - bcd2int(bv)) : bcd2int(bv)) + int'(ci);
    e.s = int2bcd(t % 10000);
    e.c = (t >= 10000);
    e.e = 1'b0;
    return e;
  endfunction

  // Issue one operation (called #1 after an edge), then wait for done and score it.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sv, input exp_t e);
    int cyc;
    exp_t got;
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge clk); #1;
    end
    a = av; b = bv; cin = ci; sub = sv; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cyc, N + 1);
    got = sb.pop_front();
    check({tag, "_sum"}, sum, got.s);
    check({tag, "_cout"}, cout, got.c);
    check({tag, "_err"}, err, got.e);
  endtask

  initial begin
    exp_t e;
    logic [15:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed additions
    e = '{16'h1000, 1'b0, 1'b0}; run_op("add_0999_0001", 16'h0999, 16'h0001, 0, 0, e);
    e = '{16'h0000, 1'b1, 1'b0}; run_op("add_9999_0001", 16'h9999, 16'h0001, 0, 0, e);
    e = '{16'h5556, 1'b0, 1'b0}; run_op("add_4321_1234c", 16'h4321, 16'h1234, 1, 0, e);

    // Invalid digit: result still produced, err flagged, then cleared
    e = '{16'h0100, 1'b0, 1'b1}; run_op("bad_00A0", 16'h00A0, 16'h0000, 0, 0, e);
    e = model(16'h0042, 16'h0058, 0, 0); run_op("after_bad", 16'h0042, 16'h0058, 0, 0, e);

    // Starts while busy are ignored
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; start = 1'b1;
    sb.push_back('{16'h3333, 1'b0, 1'b0});
    @(posedge clk); #1;                       // cycle 1
    start = 1'b0;
    @(posedge clk); #1;                       // cycle 2
    a = 16'h9999; b = 16'h9999; start = 1'b1;
    @(posedge clk); #1;                       // cycle 3
    start = 1'b0;
    check("ign_busy_c3", busy, 1);
    @(posedge clk); #1;                       // cycle 4
    @(posedge clk); #1;                       // cycle 5
    check("ign_done_c5", done, 1);
    e = sb.pop_front();
    check("ign_sum", sum, e.s);
    check("ign_cout", cout, e.c);
    a = 16'h8888; b = 16'h8888; start = 1'b1;
    @(posedge clk); #1;                       // cycle 6
    start = 1'b0;
    check("ign_idle_c6", busy, 0);
    check("ign_sum_held", sum, 16'h3333);
    e = model(16'h2468, 16'h1357, 0, 0); run_op("accept_c6", 16'h2468, 16'h1357, 0, 0, e);

    // Reset in the middle of RUN
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h1111; cin = 0; start = 1'b1;
    @(posedge clk); #1;                       // cycle 1
    start = 1'b0;
    @(posedge clk); #1;                       // cycle 2
    @(posedge clk); #1;                       // cycle 3
    check("mid_partial_sum", sum, 16'h0022);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_err", err, 0);
    @(posedge clk); #1;
    check("mid_rst_still_idle", busy, 0);
    e = model(16'h0505, 16'h0505, 1, 0); run_op("after_rst", 16'h0505, 16'h0505, 1, 0, e);

    // Random valid operands
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      e = model(ra, rb, n[0], 0);
      run_op("rand_add", ra, rb, n[0], 0, e);
    end

`ifdef BCD_SUB_EN
    e = '{16'h3766, 1'b1, 1'b0}; run_op("sub_5000_1234", 16'h5000, 16'h1234, 1, 1, e);
    e = '{16'h6234, 1'b0, 1'b0}; run_op("sub_1234_5000", 16'h1234, 16'h5000, 1, 1, e);
    e = model(16'h0777, 16'h0777, 1, 1); run_op("sub_equal", 16'h0777, 16'h0777, 1, 1, e);
`endif

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial BCD arithmetic controller. It time-shares one single-digit BCD adder across N-digit operands, one digit per clock from least to most significant, and returns an N-digit BCD result with carry-out. It sits between a requester, such as a calculator front-end or display accumulator, and the digit adder, and trades latency for area against a fully parallel N-digit adder.

## Interface
Parameters:
- N_DIGITS, 4, operand width in BCD digits (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset: one clock, synchronous, active-high
- start  in  1  request pulse; accepted only in IDLE
- a  in  4*N_DIGITS  BCD addend A, sampled on accepted start
- b  in  4*N_DIGITS  BCD addend B, sampled on accepted start
- cin  in  1  carry-in to digit 0, sampled on accepted start
- sub  in  1  subtract select (present only with BCD_SUB_EN), sampled on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse: result valid
- sum  out  4*N_DIGITS  BCD result, held until next accepted start
- cout  out  1  carry-out of the most significant digit
- err  out  1  high if any sampled A or B digit was >9; held with sum

## Operation
- States are IDLE, RUN and DONE, encoded as a 2-bit enum.
- IDLE with start=1:
  - latch a, b, cin (and sub)
  - clear the digit index, sum, cout and err
  - go to RUN
- IDLE with start=0: stay in IDLE.
- RUN, one digit per cycle at index k:
  - s5 = A[k] + B'[k] + c, computed as a 5-bit sum
  - if s5 > 9: digit = (s5+6)[3:0] and c = 1; otherwise digit = s5[3:0] and c = 0
  - write digit into sum[4k+:4] and register c
  - err |= (A[k]>9) | (B[k]>9)
  - if k = N_DIGITS-1: cout ← c and go to DONE; otherwise k ← k+1
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start while busy=1 is ignored. There is no queueing and no effect on the current operation.
- Invalid digits: the correction rule above is still applied and a result is still produced. Only err marks the result as meaningless.
- rst asserted at any point, including mid-RUN: on the next edge state ← IDLE and all outputs ← 0. The partial operation is discarded.
- Reset values: busy=0, done=0, sum=0, cout=0, err=0.

## Timing
- Accepted start on edge 0 → RUN on cycles 1..N_DIGITS → done=1 during cycle N_DIGITS+1.
- With N_DIGITS=4: done is high in cycle 5.
- Minimum start-to-start period is N_DIGITS+2 cycles. Start is next accepted in the cycle after done.
- sum is valid from the done cycle until the next accepted start. During RUN, digits above k hold 0.
- There is no combinational path from inputs to outputs.

## Configuration
- BCD_SUB_EN defined:
  - the sub port exists
  - when sub=1, B'[k] = 9 − B[k] (nine's complement); otherwise B'[k] = B[k]
  - the caller drives cin=1 for plain subtraction A−B
  - cout=1 means no borrow (A ≥ B); cout=0 means sum is the ten's complement of B−A
- BCD_SUB_EN undefined:
  - the sub port is absent and B'[k] = B[k]
  - the block is add-only

## Structure
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W = 4
  - BCD_MAX_DIGIT = 9
  - BCD_CORR = 6
  - the state enum {IDLE, RUN, DONE}
- One sub-module, bcd_digit_add: a combinational single-digit adder (a, b, cin → sum, cout) with the >9 / +6 correction. It is instantiated once and driven by the controller's digit mux.
- A separate nines-complement function lives in bcd_pkg, under BCD_SUB_EN.

## Test plan
All scenarios use N_DIGITS=4.
- a=0999, b=0001, cin=0 → done in cycle 5, sum=1000, cout=0, err=0.
- a=9999, b=0001, cin=0 → sum=0000, cout=1. Separately, a=4321, b=1234, cin=1 → sum=5556, cout=0.
- a=00A0, b=0000 → err=1 and the full 4-digit result is still produced with done in cycle 5. A following valid operation clears err.
- start pulsed in cycles 2 and 5 of an operation → both ignored, and the original result is unchanged. start in cycle 6 is accepted.
- rst asserted in cycle 3 of RUN → next cycle busy=0, sum=0, cout=0, state IDLE. A fresh start completes normally.
- BCD_SUB_EN defined:
  - a=5000, b=1234, sub=1, cin=1 → sum=3766, cout=1
  - a=1234, b=5000, sub=1, cin=1 → sum=6234, cout=0
